// File: rtl/memory_cycle.sv
// MEM stage: data memory with byte/half/word stores, sign/zero-extending loads,
// optional wait states that stall the pipeline, and the MEM/WB register.
module memory_cycle #(
  parameter int DMEM_WORDS  = 1024,
  parameter int MEM_LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  output logic        StallMem,
  output logic        MisalignM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUResultW,
  output logic [31:0] PCPlus4W,
  output logic [4:0]  RdW
);

  localparam int AW = $clog2(DMEM_WORDS);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state, nextState;
  logic [3:0] cnt, nextCnt;
  logic access, isLoad, isStore, complete, aligned, storeOk, loadOk, memWe;
  logic [AW-1:0] wordIdx;
  logic [31:0] memWord, loadData, storeData;
  logic [7:0] byteSel;
  logic [15:0] halfSel;
  logic [3:0] byteEn;
  logic [31:0] mem [DMEM_WORDS];

  assign isStore = MemWriteM;
  assign isLoad  = (ResultSrcM == 2'b01) && !MemWriteM;
  assign access  = MemWriteM | (ResultSrcM == 2'b01);
  assign wordIdx = ALUResultM[AW+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    StallMem  = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (MEM_LATENCY == 0) begin
            complete = 1'b1;
          end else begin
            StallMem  = 1'b1;
            nextCnt   = 4'(MEM_LATENCY - 1);
            nextState = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt != 4'd0) begin
          StallMem = 1'b1;
          nextCnt  = cnt - 4'd1;
        end else begin
          complete  = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
    // Reset must clear the hazard request immediately, not at the next edge
    if (rst) begin
      StallMem = 1'b0;
      complete = 1'b0;
    end
  end

  always_comb begin
    aligned = 1'b1;
    case (funct3M[1:0])
      2'b01:   aligned = !ALUResultM[0];
      2'b10:   aligned = (ALUResultM[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    storeOk = (funct3M inside {3'b000, 3'b001, 3'b010}) && aligned;
    loadOk  = (funct3M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) && aligned;
  end

  assign MisalignM = complete & ((isStore & !storeOk) | (isLoad & !loadOk));
  assign memWe     = complete & isStore & storeOk;

  always_comb begin
    byteEn    = 4'b0000;
    storeData = WriteDataM;
    case (funct3M[1:0])
      2'b00: begin
        byteEn    = 4'b0001 << ALUResultM[1:0];
        storeData = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        byteEn    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        storeData = {2{WriteDataM[15:0]}};
      end
      2'b10:   byteEn = 4'b1111;
      default: byteEn = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) mem[wordIdx][8*i +: 8] <= storeData[8*i +: 8];
      end
    end
  end

  assign memWord = mem[wordIdx];
  assign halfSel = ALUResultM[1] ? memWord[31:16] : memWord[15:0];

  always_comb begin
    case (ALUResultM[1:0])
      2'b00:   byteSel = memWord[7:0];
      2'b01:   byteSel = memWord[15:8];
      2'b10:   byteSel = memWord[23:16];
      default: byteSel = memWord[31:24];
    endcase
  end

  always_comb begin
    loadData = 32'd0;
    if (isLoad && loadOk) begin
      case (funct3M)
        3'b000:  loadData = {{24{byteSel[7]}}, byteSel};
        3'b100:  loadData = {24'd0, byteSel};
        3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
        3'b101:  loadData = {16'd0, halfSel};
        3'b010:  loadData = memWord;
        default: loadData = 32'd0;
      endcase
    end
  end

  // Stall cycles push a bubble so writeback never sees a half-finished access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ReadDataW  <= 32'd0;
      ALUResultW <= 32'd0;
      PCPlus4W   <= 32'd0;
      RdW        <= 5'd0;
    end else if (StallMem) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ReadDataW  <= 32'd0;
      ALUResultW <= 32'd0;
      PCPlus4W   <= 32'd0;
      RdW        <= 5'd0;
    end else begin
      RegWriteW  <= RegWriteM;
      ResultSrcW <= ResultSrcM;
      ReadDataW  <= loadData;
      ALUResultW <= ALUResultM;
      PCPlus4W   <= PCPlus4M;
      RdW        <= RdM;
    end
  end

endmodule

// File: tb/tb_memory_cycle.sv
// Bench for memory_cycle: two instances (no wait states / three wait states) checked
// every cycle against a byte-addressed reference memory model and a per-instruction timeline.
module tb_memory_cycle;

  localparam int LAT0 = 0;
  localparam int LAT1 = 3;

  typedef struct {
    logic        rw;
    logic        we;
    logic [1:0]  rs;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [4:0]  rd;
  } instr_t;

  typedef struct {
    logic        stall;
    logic        mis;
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        chkData;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst        [2];
  logic        regWriteM  [2];
  logic        memWriteM  [2];
  logic [1:0]  resultSrcM [2];
  logic [2:0]  funct3M    [2];
  logic [31:0] aluResultM [2];
  logic [31:0] writeDataM [2];
  logic [4:0]  rdM        [2];
  logic [31:0] pcPlus4M   [2];
  logic        stallMem   [2];
  logic        misalignM  [2];
  logic        regWriteW  [2];
  logic [1:0]  resultSrcW [2];
  logic [31:0] readDataW  [2];
  logic [31:0] aluResultW [2];
  logic [31:0] pcPlus4W   [2];
  logic [4:0]  rdW        [2];

  logic [7:0] refMem [2][4096];
  exp_t q0[$];
  exp_t q1[$];
  int nCmp = 0;
  int nMis = 0;

  always #5 clk = ~clk;

  memory_cycle #(.DMEM_WORDS(1024), .MEM_LATENCY(LAT0)) u0 (
    .clk(clk), .rst(rst[0]), .RegWriteM(regWriteM[0]), .MemWriteM(memWriteM[0]),
    .ResultSrcM(resultSrcM[0]), .funct3M(funct3M[0]), .ALUResultM(aluResultM[0]),
    .WriteDataM(writeDataM[0]), .RdM(rdM[0]), .PCPlus4M(pcPlus4M[0]),
    .StallMem(stallMem[0]), .MisalignM(misalignM[0]), .RegWriteW(regWriteW[0]),
    .ResultSrcW(resultSrcW[0]), .ReadDataW(readDataW[0]), .ALUResultW(aluResultW[0]),
    .PCPlus4W(pcPlus4W[0]), .RdW(rdW[0]));

  memory_cycle #(.DMEM_WORDS(1024), .MEM_LATENCY(LAT1)) u1 (
    .clk(clk), .rst(rst[1]), .RegWriteM(regWriteM[1]), .MemWriteM(memWriteM[1]),
    .ResultSrcM(resultSrcM[1]), .funct3M(funct3M[1]), .ALUResultM(aluResultM[1]),
    .WriteDataM(writeDataM[1]), .RdM(rdM[1]), .PCPlus4M(pcPlus4M[1]),
    .StallMem(stallMem[1]), .MisalignM(misalignM[1]), .RegWriteW(regWriteW[1]),
    .ResultSrcW(resultSrcW[1]), .ReadDataW(readDataW[1]), .ALUResultW(aluResultW[1]),
    .PCPlus4W(pcPlus4W[1]), .RdW(rdW[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t zeroExp(input logic stall, input logic chkData);
    exp_t e;
    e.stall = stall; e.mis = 1'b0; e.rw = 1'b0; e.rs = 2'b00; e.rdata = 32'd0;
    e.alu = 32'd0; e.pc = 32'd0; e.rd = 5'd0; e.chkData = chkData;
    return e;
  endfunction

  // Reference: byte-addressed memory, address wraps at 4 KiB (1024 words)
  task automatic runModel(input int k, input instr_t in, output exp_t e, output logic mis);
    int unsigned ba, n;
    logic isLoad, storeOk, loadOk;
    logic [31:0] v, tmp;
    ba      = in.alu & 32'hFFF;
    n       = 1 << in.f3[1:0];
    isLoad  = (in.rs == 2'b01) && !in.we;
    storeOk = in.we && (in.f3 <= 3'd2) && ((ba % n) == 0);
    loadOk  = isLoad && (in.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && ((ba % n) == 0);
    mis     = (in.we && !storeOk) || (isLoad && !loadOk);
    if (storeOk) begin
      for (int i = 0; i < int'(n); i++) begin
        tmp = in.wd >> (8 * i);
        refMem[k][ba + i] = tmp[7:0];
      end
    end
    v = 32'd0;
    if (loadOk) begin
      for (int i = 0; i < int'(n); i++) v = v | ({24'd0, refMem[k][ba + i]} << (8 * i));
      if (!in.f3[2] && n < 4 && v[8 * n - 1]) v = v | (32'hFFFFFFFF << (8 * n));
    end
    e.stall = 1'b0; e.mis = mis; e.rw = in.rw; e.rs = in.rs; e.rdata = v;
    e.alu = in.alu; e.pc = in.pc; e.rd = in.rd; e.chkData = (in.rs == 2'b01);
  endtask

  task automatic drive(input int k, input instr_t in);
    regWriteM[k] = in.rw;  memWriteM[k] = in.we;   resultSrcM[k] = in.rs;
    funct3M[k]   = in.f3;  aluResultM[k] = in.alu; writeDataM[k] = in.wd;
    rdM[k]       = in.rd;  pcPlus4M[k]   = in.pc;
  endtask

  function automatic instr_t idleInstr();
    instr_t in;
    in.rw = 1'b0; in.we = 1'b0; in.rs = 2'b00; in.f3 = 3'd0;
    in.alu = 32'd0; in.wd = 32'd0; in.pc = 32'd0; in.rd = 5'd0;
    return in;
  endfunction

  function automatic instr_t mk(input logic rw, input logic we, input logic [1:0] rs,
                                input logic [2:0] f3, input logic [31:0] alu,
                                input logic [31:0] wd, input logic [4:0] rd);
    instr_t in;
    in.rw = rw; in.we = we; in.rs = rs; in.f3 = f3; in.alu = alu; in.wd = wd;
    in.pc = alu ^ 32'h0040_0004; in.rd = rd;
    return in;
  endfunction

  // An access occupies MEM_LATENCY stall cycles plus its completion cycle
  task automatic issue(input int k, input instr_t in);
    exp_t e, cyc;
    logic mis;
    int lat;
    runModel(k, in, e, mis);
    lat = (in.we || in.rs == 2'b01) ? ((k == 0) ? LAT0 : LAT1) : 0;
    for (int c = 0; c <= lat; c++) begin
      drive(k, in);
      cyc = (c < lat) ? zeroExp(1'b1, 1'b1) : e;
      if (k == 0) begin q0.push_back(cyc); q1.push_back(zeroExp(1'b0, 1'b0)); end
      else        begin q1.push_back(cyc); q0.push_back(zeroExp(1'b0, 1'b0)); end
      @(negedge clk);
    end
    drive(k, idleInstr());
  endtask

  task automatic chkComb(input int k, input exp_t e);
    chk($sformatf("stall%0d", k), 32'(stallMem[k]), 32'(e.stall));
    chk($sformatf("misalign%0d", k), 32'(misalignM[k]), 32'(e.mis));
  endtask

  task automatic chkW(input int k, input exp_t e);
    chk($sformatf("RegWriteW%0d", k), 32'(regWriteW[k]), 32'(e.rw));
    chk($sformatf("ResultSrcW%0d", k), 32'(resultSrcW[k]), 32'(e.rs));
    chk($sformatf("ALUResultW%0d", k), aluResultW[k], e.alu);
    chk($sformatf("PCPlus4W%0d", k), pcPlus4W[k], e.pc);
    chk($sformatf("RdW%0d", k), 32'(rdW[k]), 32'(e.rd));
    if (e.chkData) chk($sformatf("ReadDataW%0d", k), readDataW[k], e.rdata);
  endtask

  task automatic chkResetState(input int k);
    chk($sformatf("rst_stall%0d", k), 32'(stallMem[k]), 32'd0);
    chk($sformatf("rst_regwrite%0d", k), 32'(regWriteW[k]), 32'd0);
    chk($sformatf("rst_resultsrc%0d", k), 32'(resultSrcW[k]), 32'd0);
    chk($sformatf("rst_readdata%0d", k), readDataW[k], 32'd0);
    chk($sformatf("rst_alu%0d", k), aluResultW[k], 32'd0);
    chk($sformatf("rst_pc%0d", k), pcPlus4W[k], 32'd0);
    chk($sformatf("rst_rd%0d", k), 32'(rdW[k]), 32'd0);
  endtask

  initial begin : compare
    exp_t e0, e1;
    logic have0, have1;
    forever begin
      @(negedge clk); #2;
      have0 = (q0.size() > 0);
      have1 = (q1.size() > 0);
      if (have0) begin e0 = q0[0]; chkComb(0, e0); end
      if (have1) begin e1 = q1[0]; chkComb(1, e1); end
      @(posedge clk); #1;
      if (have0) begin chkW(0, e0); void'(q0.pop_front()); end
      if (have1) begin chkW(1, e1); void'(q1.pop_front()); end
    end
  end

  task automatic randomRun(input int k, input int count);
    instr_t in;
    int kind;
    logic [2:0] ldOk [5];
    ldOk = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < count; i++) begin
      kind   = $urandom_range(0, 9);
      in.rw  = 1'($urandom);
      in.rd  = 5'($urandom);
      in.pc  = $urandom;
      in.wd  = $urandom;
      in.alu = ($urandom_range(0, 1) ? ($urandom & 32'hFFFF_F000) : 32'd0) | 32'($urandom_range(0, 63));
      in.f3  = 3'($urandom);
      in.we  = 1'b0;
      in.rs  = 2'b00;
      if (kind <= 2) begin
        in.rs  = $urandom_range(0, 1) ? 2'b10 : 2'b00;
        in.alu = $urandom;
      end else if (kind <= 5) begin
        in.rs = 2'b01;
        if ($urandom_range(0, 3) != 0) in.f3 = ldOk[$urandom_range(0, 4)];
      end else begin
        in.we = 1'b1;
        if (kind == 9) in.rs = 2'b01;
        if ($urandom_range(0, 3) != 0) in.f3 = 3'($urandom_range(0, 2));
      end
      issue(k, in);
    end
  endtask

  initial begin : main
    instr_t sw;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      drive(k, idleInstr());
    end
    @(posedge clk); #2;
    chkResetState(0);
    chkResetState(1);
    chk("rst_misalign0", 32'(misalignM[0]), 32'd0);
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Known contents for the whole 64-byte test window
    for (int k = 0; k < 2; k++)
      for (int w = 0; w < 16; w++)
        issue(k, mk(1'b0, 1'b1, 2'b00, 3'd2, 32'(4 * w), $urandom, 5'd0));

    // No wait states: word store then load
    issue(0, mk(1'b0, 1'b1, 2'b00, 3'd2, 32'h10, 32'hDEADBEEF, 5'd0));
    issue(0, mk(1'b1, 1'b0, 2'b01, 3'd2, 32'h10, 32'd0, 5'd5));
    chk("t1_rd", 32'(rdW[0]), 32'd5);
    chk("t1_regwrite", 32'(regWriteW[0]), 32'd1);
    chk("t1_lw", readDataW[0], 32'hDEADBEEF);

    // Byte lanes and extension
    issue(0, mk(1'b0, 1'b1, 2'b00, 3'd0, 32'h12, 32'h000000EF, 5'd0));
    issue(0, mk(1'b0, 1'b1, 2'b00, 3'd0, 32'h13, 32'h12345680, 5'd0));
    issue(0, mk(1'b1, 1'b0, 2'b01, 3'd0, 32'h13, 32'd0, 5'd6));
    chk("t2_lb", readDataW[0], 32'hFFFFFF80);
    issue(0, mk(1'b1, 1'b0, 2'b01, 3'd4, 32'h13, 32'd0, 5'd6));
    chk("t2_lbu", readDataW[0], 32'h00000080);
    issue(0, mk(1'b1, 1'b0, 2'b01, 3'd1, 32'h12, 32'd0, 5'd6));
    chk("t2_lh", readDataW[0], 32'hFFFF80EF);

    // Misaligned store is dropped; misaligned load returns zero but still writes back
    issue(0, mk(1'b0, 1'b1, 2'b00, 3'd2, 32'h20, 32'hCAFEF00D, 5'd0));
    issue(0, mk(1'b0, 1'b1, 2'b00, 3'd2, 32'h22, 32'h11111111, 5'd0));
    issue(0, mk(1'b1, 1'b0, 2'b01, 3'd2, 32'h20, 32'd0, 5'd8));
    chk("t4_word_kept", readDataW[0], 32'hCAFEF00D);
    issue(0, mk(1'b1, 1'b0, 2'b01, 3'd1, 32'h11, 32'd0, 5'd9));
    chk("t4_lh_misaligned", readDataW[0], 32'd0);
    chk("t4_regwrite", 32'(regWriteW[0]), 32'd1);

    // Plain ALU result passes straight through
    issue(0, mk(1'b1, 1'b0, 2'b00, 3'd0, 32'h1234, 32'd0, 5'd7));
    chk("t6_alu", aluResultW[0], 32'h1234);
    chk("t6_rd", 32'(rdW[0]), 32'd7);

    // Three wait states
    issue(1, mk(1'b0, 1'b1, 2'b00, 3'd2, 32'h04, 32'h0BADF00D, 5'd0));
    issue(1, mk(1'b1, 1'b0, 2'b01, 3'd2, 32'h04, 32'd0, 5'd3));
    chk("t3_lw", readDataW[1], 32'h0BADF00D);
    chk("t3_rd", 32'(rdW[1]), 32'd3);

    randomRun(0, 300);
    randomRun(1, 200);

    // Reset while a store is waiting: no write, outputs clear without a clock edge
    sw = mk(1'b1, 1'b1, 2'b00, 3'd2, 32'h30, 32'h55AA55AA, 5'd4);
    drive(1, sw);
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("t5_stall_before", 32'(stallMem[1]), 32'd1);
    rst[1] = 1'b1;
    #1;
    chkResetState(1);
    @(posedge clk); #1;
    chk("t5_stall_in_reset", 32'(stallMem[1]), 32'd0);
    @(negedge clk);
    drive(1, idleInstr());
    rst[1] = 1'b0;
    issue(1, mk(1'b1, 1'b0, 2'b01, 3'd2, 32'h30, 32'd0, 5'd2));
    issue(1, mk(1'b1, 1'b0, 2'b00, 3'd0, 32'h0, 32'd0, 5'd0));

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
    $finish;
  end

endmodule
